sram_rmw_ctrl: RTL and testbench

Parametrised read-modify-write engine for the external asynchronous SRAM on the iceFUN board. On a `start` request it walks `len` consecutive words from `base_addr`: each word is read, `addend` is added to it, and the result is written back, with a programmable number of wait states per phase. The host microcontroller grants bus ownership through `fpga_enable`. Whenever the grant is absent the block releases every SRAM pin, including in the middle of a job.

---
 rtl/sram_rmw_pkg.sv | 42 ++++
 rtl/sram_pad_if.sv | 38 +++
 rtl/sram_rmw_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rmw_pkg.sv
// Purpose: shared types and constants for the SRAM read-modify-write engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default widths, FSM state enum, SRAM strobe bundle and its per-phase levels.
package sram_rmw_pkg;

  localparam int ADDR_W_DEF   = 22;
  localparam int DATA_W_DEF   = 16;
  localparam int LEN_W_DEF    = 8;
  localparam int WAIT_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_SUM,
    ST_WR,
    ST_RECOV
  } state_e;

  // SRAM control pins; all active low except ce2.
  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic lb;
    logic ub;
    logic ce2;
  } strobe_t;

  localparam strobe_t STB_IDLE  = '{ce: 1'b1, oe: 1'b1, we: 1'b1, lb: 1'b1, ub: 1'b1, ce2: 1'b0};
  localparam strobe_t STB_READ  = '{ce: 1'b0, oe: 1'b0, we: 1'b1, lb: 1'b0, ub: 1'b0, ce2: 1'b1};
  // Chip stays selected between read and write, output enable released.
  localparam strobe_t STB_HOLD  = '{ce: 1'b0, oe: 1'b1, we: 1'b1, lb: 1'b0, ub: 1'b0, ce2: 1'b1};
  localparam strobe_t STB_WRITE = '{ce: 1'b0, oe: 1'b1, we: 1'b0, lb: 1'b0, ub: 1'b0, ce2: 1'b1};

  // Width of the wait-state down-counter (counts WAIT_CYC-1 .. 0).
  function automatic int wait_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_pad_if.sv
// Purpose: tri-state pad drivers for the external SRAM address, data and strobes.
// Latency: combinational; pins follow the registered controls from the engine.
// Backpressure: none; pins float whenever own is low, data drives only when drive_dat is high.
// Ports: own/drive_dat enables, addr_i/wdata_i/stb_i values, rdata_o sampled bus, SRAM pins.
module sram_pad_if
  import sram_rmw_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              own,
  input  logic              drive_dat,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  strobe_t           stb_i,
  output logic [DATA_W-1:0] rdata_o,
  output wire  [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output wire               ce,
  output wire               oe,
  output wire               we,
  output wire               lb,
  output wire               ub,
  output wire               ce2
);

  assign addr = own ? addr_i : {ADDR_W{1'bz}};
  assign data = (own && drive_dat) ? wdata_i : {DATA_W{1'bz}};
  assign ce   = own ? stb_i.ce  : 1'bz;
  assign oe   = own ? stb_i.oe  : 1'bz;
  assign we   = own ? stb_i.we  : 1'bz;
  assign lb   = own ? stb_i.lb  : 1'bz;
  assign ub   = own ? stb_i.ub  : 1'bz;
  assign ce2  = own ? stb_i.ce2 : 1'bz;

  assign rdata_o = data;

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Purpose: walks len SRAM words from base_addr, adding addend to each (read, sum, write back).
// Latency: busy for len*(2*WAIT_CYC+3) clocks after accept; done/aborted one-cycle pulses.
// Backpressure: start is only taken in IDLE with fpga_enable high; grant loss aborts and floats pins.
// Ports: clk/rst, fpga_enable grant, start/base_addr/len/addend job request,
//        busy/done/aborted/word_cnt status, addr/data/ce/oe/we/lb/ub/ce2 SRAM pins.
// Option: define SRAM_RMW_SATURATE_EN to clamp the sum at all-ones instead of wrapping.
module sram_rmw_ctrl
  import sram_rmw_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpga_enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] addend,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  word_cnt,
  output wire  [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output wire               ce,
  output wire               oe,
  output wire               we,
  output wire               lb,
  output wire               ub,
  output wire               ce2
);

  localparam int             WCW       = wait_cnt_w(WAIT_CYC);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] addend_q, addend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              own_q, own_d;
  logic              drv_q, drv_d;
  strobe_t           stb_q, stb_d;
  logic [DATA_W-1:0] pad_rdata;
  logic [DATA_W-1:0] sum_res;

`ifdef SRAM_RMW_SATURATE_EN
  logic [DATA_W:0] sum_full;
  assign sum_full = {1'b0, rdata_q} + {1'b0, addend_q};
  assign sum_res  = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
  assign sum_res  = rdata_q + addend_q;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    word_cnt_d = word_cnt_q;
    addend_d   = addend_q;
    rdata_d    = rdata_q;
    sum_d      = sum_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && fpga_enable) begin
          addr_d     = base_addr;
          rem_d      = len;
          addend_d   = addend;
          word_cnt_d = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RD;
            wait_d  = WAIT_LAST;
          end
        end
      end
      ST_RD: begin
        // Capture at the end of the last read cycle: full WAIT_CYC clocks of access time.
        if (wait_q == '0) begin
          state_d = ST_LATCH;
          rdata_d = pad_rdata;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_LATCH: state_d = ST_SUM;
      ST_SUM: begin
        state_d = ST_WR;
        wait_d  = WAIT_LAST;
        sum_d   = sum_res;
      end
      ST_WR: begin
        if (wait_q == '0) state_d = ST_RECOV;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_RECOV: begin
        word_cnt_d = word_cnt_q + 1'b1;
        addr_d     = addr_q + 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = ST_RD;
          wait_d  = WAIT_LAST;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant loss overrides everything: the in-flight word is neither counted nor advanced.
    if (state_q != ST_IDLE && !fpga_enable) begin
      state_d    = ST_IDLE;
      aborted_d  = 1'b1;
      done_d     = 1'b0;
      word_cnt_d = word_cnt_q;
      addr_d     = addr_q;
    end

    busy_d = (state_d != ST_IDLE);
    own_d  = fpga_enable;
    // Data stays driven through RECOV so it holds past the rising edge of we.
    drv_d  = (state_d == ST_WR) || (state_d == ST_RECOV);

    case (state_d)
      ST_RD:             stb_d = STB_READ;
      ST_LATCH, ST_SUM:  stb_d = STB_HOLD;
      ST_WR:             stb_d = STB_WRITE;
      ST_RECOV:          stb_d = STB_HOLD;
      default:           stb_d = STB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      word_cnt_q <= '0;
      addend_q   <= '0;
      rdata_q    <= '0;
      sum_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      own_q      <= 1'b0;
      drv_q      <= 1'b0;
      stb_q      <= STB_IDLE;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      word_cnt_q <= word_cnt_d;
      addend_q   <= addend_d;
      rdata_q    <= rdata_d;
      sum_q      <= sum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      own_q      <= own_d;
      drv_q      <= drv_d;
      stb_q      <= stb_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign word_cnt = word_cnt_q;

  sram_pad_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pad (
    .own       (own_q),
    .drive_dat (drv_q),
    .addr_i    (addr_q),
    .wdata_i   (sum_q),
    .stb_i     (stb_q),
    .rdata_o   (pad_rdata),
    .addr      (addr),
    .data      (data),
    .ce        (ce),
    .oe        (oe),
    .we        (we),
    .lb        (lb),
    .ub        (ub),
    .ce2       (ce2)
  );

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Purpose: self-checking bench for sram_rmw_ctrl with a behavioural async SRAM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
// Released SRAM control pins are pulled low here, so a floating ce reads 0 (driven idle is 1).
module tb_sram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpga_enable;
  logic        start;
  logic [21:0] base_addr;
  logic [7:0]  len;
  logic [15:0] addend;
  logic        busy, done, aborted;
  logic [7:0]  word_cnt;
  wire  [21:0] addr;
  wire  [15:0] data;
  wire         ce, oe, we, lb, ub, ce2;

  pulldown (ce);
  pulldown (oe);
  pulldown (we);
  pulldown (lb);
  pulldown (ub);
  pulldown (ce2);

  sram_rmw_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fpga_enable (fpga_enable),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .addend      (addend),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .word_cnt    (word_cnt),
    .addr        (addr),
    .data        (data),
    .ce          (ce),
    .oe          (oe),
    .we          (we),
    .lb          (lb),
    .ub          (ub),
    .ce2         (ce2)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [15:0] mem [logic [21:0]];
  logic [15:0] rd_val = 16'h0;
  wire sram_rd_en = (ce == 1'b0) && (oe == 1'b0) && (we == 1'b1) && (ce2 == 1'b1);
  assign data = sram_rd_en ? rd_val : 16'hzzzz;

  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  int busy_cyc  = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int act_cyc   = 0;

  always @(negedge clk) begin
    if (ce == 1'b0 && we == 1'b0 && ce2 == 1'b1) mem[addr] = data;
    rd_val = mem_rd(addr);
    if (busy)    busy_cyc++;
    if (done)    done_cnt++;
    if (aborted) abort_cnt++;
    if (ce == 1'b0 && ce2 == 1'b1) act_cyc++;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int busy;
    int words;
    int dones;
    int aborts;
  } job_t;

  typedef struct {
    logic [21:0] a;
    logic [15:0] d;
  } mem_exp_t;

  job_t     job_q[$];
  mem_exp_t mem_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_mem(input logic [21:0] a, input logic [15:0] d);
    mem_exp_t e;
    e.a = a;
    e.d = d;
    mem_q.push_back(e);
  endtask

  task automatic drain_mem(input string tag);
    mem_exp_t e;
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      check_vec({tag, "_mem"}, {16'h0, mem_rd(e.a)}, {16'h0, e.d});
    end
  endtask

  // drop_at >= 0: release the grant that many cycles after the first busy cycle.
  task automatic run_job(input string tag, input logic [21:0] b, input logic [7:0] n,
                         input logic [15:0] a, input int exp_busy, input int exp_words,
                         input bit exp_abort, input int drop_at);
    job_t j;
    int   b0, d0, a0;
    bit   seen;
    j.busy   = exp_busy;
    j.words  = exp_words;
    j.dones  = exp_abort ? 0 : 1;
    j.aborts = exp_abort ? 1 : 0;
    job_q.push_back(j);
    b0 = busy_cyc;
    d0 = done_cnt;
    a0 = abort_cnt;
    base_addr = b;
    len       = n;
    addend    = a;
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (drop_at >= 0) begin
      repeat (drop_at) tick();
      fpga_enable = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done || aborted) seen = 1'b1;
      else tick();
    end
    check_vec({tag, "_finish_seen"}, {31'h0, seen}, 32'h1);
    if (exp_abort) begin
      check_vec({tag, "_ce_released"}, {31'h0, ce}, 32'h0);
      check_vec({tag, "_we_released"}, {31'h0, we}, 32'h0);
    end
    tick();
    tick();
    j = job_q.pop_front();
    check_vec({tag, "_busy_cycles"}, busy_cyc - b0, j.busy);
    check_vec({tag, "_done_pulses"}, done_cnt - d0, j.dones);
    check_vec({tag, "_abort_pulses"}, abort_cnt - a0, j.aborts);
    check_vec({tag, "_word_cnt"}, {24'h0, word_cnt}, j.words);
    if (exp_abort) begin
      fpga_enable = 1'b1;
      tick();
      tick();
    end
    drain_mem(tag);
  endtask

  initial begin
    int b0, d0, a0, c0;
    rst         = 1'b1;
    fpga_enable = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    len         = '0;
    addend      = '0;
    repeat (3) tick();

    // Reset state: outputs cleared, SRAM pins released.
    check_vec("rst_busy", {31'h0, busy}, 32'h0);
    check_vec("rst_done", {31'h0, done}, 32'h0);
    check_vec("rst_aborted", {31'h0, aborted}, 32'h0);
    check_vec("rst_word_cnt", {24'h0, word_cnt}, 32'h0);
    check_vec("rst_ce_released", {31'h0, ce}, 32'h0);

    rst = 1'b0;
    fpga_enable = 1'b1;
    tick();
    tick();
    check_vec("idle_ce_driven", {31'h0, ce}, 32'h1);
    check_vec("idle_oe_driven", {31'h0, oe}, 32'h1);
    check_vec("idle_we_driven", {31'h0, we}, 32'h1);
    check_vec("idle_ce2_low", {31'h0, ce2}, 32'h0);

    // Single word.
    mem[22'h3] = 16'h0005;
    expect_mem(22'h3, 16'h0015);
    run_job("single", 22'h3, 8'd1, 16'h0010, 7, 1, 1'b0, -1);

    // Address wrap past top of memory.
    for (int i = 0; i < 4; i++) expect_mem(22'h3FFFFE + 22'(i), 16'h0001);
    run_job("wrap", 22'h3FFFFE, 8'd4, 16'h0001, 28, 4, 1'b0, -1);

    // Carry-out behaviour.
    mem[22'h0] = 16'hFFF0;
`ifdef SRAM_RMW_SATURATE_EN
    expect_mem(22'h0, 16'hFFFF);
`else
    expect_mem(22'h0, 16'h0010);
`endif
    run_job("carry", 22'h0, 8'd1, 16'h0020, 7, 1, 1'b0, -1);

    // Grant dropped in the third word's first WR cycle (busy cycle 18).
    for (int i = 0; i < 5; i++) mem[22'h100 + 22'(i)] = 16'h1000 + 16'(i);
    expect_mem(22'h100, 16'h1007);
    expect_mem(22'h101, 16'h1008);
    expect_mem(22'h103, 16'h1003);
    expect_mem(22'h104, 16'h1004);
    run_job("abort", 22'h100, 8'd5, 16'h0007, 19, 2, 1'b1, 18);

    // Start without grant is ignored.
    fpga_enable = 1'b0;
    tick();
    b0 = busy_cyc; d0 = done_cnt; a0 = abort_cnt;
    base_addr = 22'h40;
    len       = 8'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_vec("nogrant_busy_cycles", busy_cyc - b0, 0);
    check_vec("nogrant_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    check_vec("nogrant_ce_released", {31'h0, ce}, 32'h0);
    fpga_enable = 1'b1;
    tick();
    tick();

    // len=0: immediate done, no bus activity.
    c0 = act_cyc;
    run_job("len0", 22'h50, 8'd0, 16'h0001, 0, 0, 1'b0, -1);
    check_vec("len0_bus_activity", act_cyc - c0, 0);

    // Reset during the second word's RD, then a normal job.
    b0 = busy_cyc; d0 = done_cnt; a0 = abort_cnt;
    base_addr = 22'h200;
    len       = 8'd3;
    addend    = 16'h0001;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check_vec("midrst_busy", {31'h0, busy}, 32'h0);
    check_vec("midrst_word_cnt", {24'h0, word_cnt}, 32'h0);
    check_vec("midrst_ce_released", {31'h0, ce}, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check_vec("midrst_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    check_vec("midrst_busy_cycles", busy_cyc - b0, 8);

    expect_mem(22'h300, 16'h0003);
    expect_mem(22'h301, 16'h0003);
    run_job("after_rst", 22'h300, 8'd2, 16'h0003, 14, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
